// File: rtl/mux_arb_n.sv
// N-channel valid/ready multiplexer with forced-index or arbitrated selection
// (fixed priority or round-robin) feeding a single registered output stage.
module mux_arb_n #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int IDX_W = 2,
  parameter int RR    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mode,
  input  logic [IDX_W-1:0]     sel_index,
  input  logic [N-1:0]         in_valid,
  input  logic [N*WIDTH-1:0]   in_data,
  output logic [N-1:0]         in_ready,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic [IDX_W-1:0]     out_index,
  input  logic                 out_ready
);

  localparam logic [IDX_W:0]   N_EXT    = (IDX_W+1)'(N);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N-1);

  logic [WIDTH-1:0] chan_data [N];

  logic             out_valid_reg, out_valid_next;
  logic [WIDTH-1:0] out_data_reg,  out_data_next;
  logic [IDX_W-1:0] out_index_reg, out_index_next;
  logic [IDX_W-1:0] ptr_reg,       ptr_next;

  logic             load;
  logic             forced_hit;
  logic             fp_hit;
  logic [IDX_W-1:0] fp_idx;
  logic             rr_hit;
  logic [IDX_W-1:0] rr_idx;
  logic             grant_any;
  logic [IDX_W-1:0] grant_idx;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_chan
      assign chan_data[gi] = in_data[gi*WIDTH +: WIDTH];
      assign in_ready[gi]  = grant_any && (grant_idx == IDX_W'(gi));
    end
  endgenerate

  assign load = !out_valid_reg || out_ready;

  // Out-of-range indices (non-power-of-2 N) simply never grant.
  always_comb begin
    forced_hit = 1'b0;
    if ({1'b0, sel_index} < N_EXT) begin
      forced_hit = in_valid[sel_index];
    end
  end

  // Descending scan so the lowest-numbered requester wins.
  always_comb begin
    fp_hit = 1'b0;
    fp_idx = '0;
    for (int i = N-1; i >= 0; i--) begin
      if (in_valid[i]) begin
        fp_hit = 1'b1;
        fp_idx = IDX_W'(i);
      end
    end
  end

  // Same trick from the pointer: smallest offset from ptr wins.
  always_comb begin
    int idx;
    idx    = 0;
    rr_hit = 1'b0;
    rr_idx = '0;
    for (int k = N-1; k >= 0; k--) begin
      idx = (int'(ptr_reg) + k) % N;
      if (in_valid[idx]) begin
        rr_hit = 1'b1;
        rr_idx = idx[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    if (!rst && load) begin
      if (mode) begin
        grant_any = forced_hit;
        grant_idx = sel_index;
      end else if (RR != 0) begin
        grant_any = rr_hit;
        grant_idx = rr_idx;
      end else begin
        grant_any = fp_hit;
        grant_idx = fp_idx;
      end
    end
  end

  always_comb begin
    out_valid_next = out_valid_reg;
    out_data_next  = out_data_reg;
    out_index_next = out_index_reg;
    ptr_next       = ptr_reg;
    if (grant_any) begin
      out_valid_next = 1'b1;
      out_data_next  = chan_data[grant_idx];
      out_index_next = grant_idx;
      if (!mode && (RR != 0)) begin
        ptr_next = (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
      end
    end else if (load) begin
      out_valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_index_reg <= '0;
      ptr_reg       <= '0;
    end else begin
      out_valid_reg <= out_valid_next;
      out_data_reg  <= out_data_next;
      out_index_reg <= out_index_next;
      ptr_reg       <= ptr_next;
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_index = out_index_reg;

endmodule

// File: tb/tb_mux_arb_n.sv
// Bench for mux_arb_n: a round-robin and a fixed-priority instance share
// stimulus and are both checked against a cycle-level reference model.
module tb_mux_arb_n;

  localparam int W  = 32;
  localparam int N  = 4;
  localparam int IW = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           mode = 1'b0;
  logic [IW-1:0]  sel_index = '0;
  logic [N-1:0]   in_valid = '0;
  logic [N*W-1:0] in_data = '0;
  logic           out_ready = 1'b0;

  logic [N-1:0]   rdy_a, rdy_b;
  logic           ov_a, ov_b;
  logic [W-1:0]   od_a, od_b;
  logic [IW-1:0]  oi_a, oi_b;

  int checks = 0;
  int errors = 0;

  // Model state: index 0 = round-robin instance, 1 = fixed-priority instance
  bit       m_valid [2];
  logic [W-1:0] m_data [2];
  int       m_index [2];
  int       m_ptr   [2];

  always #5 clk = ~clk;

  mux_arb_n #(.WIDTH(W), .N(N), .IDX_W(IW), .RR(1)) dut_rr (
    .clk(clk), .rst(rst), .mode(mode), .sel_index(sel_index),
    .in_valid(in_valid), .in_data(in_data), .in_ready(rdy_a),
    .out_valid(ov_a), .out_data(od_a), .out_index(oi_a), .out_ready(out_ready)
  );

  mux_arb_n #(.WIDTH(W), .N(N), .IDX_W(IW), .RR(0)) dut_fp (
    .clk(clk), .rst(rst), .mode(mode), .sel_index(sel_index),
    .in_valid(in_valid), .in_data(in_data), .in_ready(rdy_b),
    .out_valid(ov_b), .out_data(od_b), .out_index(oi_b), .out_ready(out_ready)
  );

  // Granted channel per the selection rules, or -1 for none.
  function automatic int model_grant(input bit rr, input int ptr, input bit md,
                                     input int sel, input logic [N-1:0] v,
                                     input bit ov, input bit ordy, input bit r);
    if (r || (ov && !ordy)) return -1;
    if (md) return (sel < N && v[sel]) ? sel : -1;
    for (int k = 0; k < N; k++) begin
      int i;
      i = rr ? (ptr + k) % N : k;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  task automatic tick(input string tag);
    int g [2];
    logic [N-1:0] exp_rdy, act_rdy;
    logic [W-1:0] act_d;
    logic [IW-1:0] act_i, exp_i;
    logic act_v;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      g[d] = model_grant(d == 0, m_ptr[d], mode, int'(sel_index), in_valid,
                         m_valid[d], out_ready, rst);
      exp_rdy = '0;
      if (g[d] >= 0) exp_rdy[g[d]] = 1'b1;
      act_rdy = (d == 0) ? rdy_a : rdy_b;
      checks++;
      if (act_rdy !== exp_rdy) begin
        errors++;
        $display("FAIL %s in_ready dut%0d got %b exp %b", tag, d, act_rdy, exp_rdy);
      end
    end
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        m_valid[d] = 1'b0; m_data[d] = '0; m_index[d] = 0; m_ptr[d] = 0;
      end else if (g[d] >= 0) begin
        m_valid[d] = 1'b1;
        m_data[d]  = in_data[g[d]*W +: W];
        m_index[d] = g[d];
        if (!mode && d == 0) m_ptr[d] = (g[d] + 1) % N;
      end else if (!m_valid[d] || out_ready) begin
        m_valid[d] = 1'b0;
      end
    end
    #1;
    for (int d = 0; d < 2; d++) begin
      act_v = (d == 0) ? ov_a : ov_b;
      act_d = (d == 0) ? od_a : od_b;
      act_i = (d == 0) ? oi_a : oi_b;
      exp_i = IW'(m_index[d]);
      checks++;
      if (act_v !== m_valid[d] || act_d !== m_data[d] || act_i !== exp_i) begin
        errors++;
        $display("FAIL %s out dut%0d got v=%b d=%h i=%0d exp v=%b d=%h i=%0d",
                 tag, d, act_v, act_d, act_i, m_valid[d], m_data[d], exp_i);
      end
    end
    $display("%s: rst=%b mode=%b sel=%0d v=%b ordy=%b | rr v=%b i=%0d d=%h | fp v=%b i=%0d d=%h",
             tag, rst, mode, sel_index, in_valid, out_ready, ov_a, oi_a, od_a, ov_b, oi_b, od_b);
  endtask

  task automatic fill_data();
    for (int i = 0; i < N; i++) in_data[i*W +: W] = $urandom;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = '1; out_ready = 1'b1; mode = 1'b0; fill_data();
    tick("reset0");
    tick("reset1");
    checks++;
    if (ov_a !== 1'b0 || od_a !== '0 || oi_a !== '0) begin
      errors++;
      $display("FAIL reset_state got v=%b d=%h i=%0d exp v=0 d=0 i=0", ov_a, od_a, oi_a);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (rdy_a !== 4'b0001) begin
      errors++;
      $display("FAIL reset_first_grant got %b exp 0001", rdy_a);
    end
    tick("reset_rel");
  endtask

  task automatic test_forced();
    mode = 1'b1; sel_index = 2'd2; in_valid = 4'b1111; out_ready = 1'b1; fill_data();
    in_data[2*W +: W] = 32'hDEADBEEF;
    #1;
    checks++;
    if (rdy_a !== 4'b0100) begin
      errors++;
      $display("FAIL forced_ready got %b exp 0100", rdy_a);
    end
    tick("forced");
    checks++;
    if (ov_a !== 1'b1 || od_a !== 32'hDEADBEEF || oi_a !== 2'd2) begin
      errors++;
      $display("FAIL forced_out got v=%b d=%h i=%0d exp v=1 d=deadbeef i=2", ov_a, od_a, oi_a);
    end
    in_valid = 4'b1011;
    tick("forced_none");
    checks++;
    if (ov_a !== 1'b0) begin
      errors++;
      $display("FAIL forced_none got v=%b exp 0", ov_a);
    end
  endtask

  task automatic test_fairness();
    rst = 1'b1; tick("fair_rst");
    rst = 1'b0; mode = 1'b0; in_valid = 4'b1111; out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      fill_data();
      tick("fair");
      checks++;
      if (ov_a !== 1'b1 || oi_a !== IW'(k % N) || ov_b !== 1'b1 || oi_b !== 2'd0) begin
        errors++;
        $display("FAIL fairness step %0d got rr=%0d fp=%0d exp rr=%0d fp=0", k, oi_a, oi_b, k % N);
      end
    end
  endtask

  task automatic test_back_to_back();
    mode = 1'b1; sel_index = 2'd0; in_valid = 4'b0001; out_ready = 1'b1; fill_data();
    in_data[0 +: W] = 32'h1;
    tick("bp_load");
    out_ready = 1'b0; mode = 1'b0; in_valid = 4'b0010; fill_data();
    for (int k = 0; k < 3; k++) begin
      tick("bp_hold");
      checks++;
      if (ov_a !== 1'b1 || od_a !== 32'h1 || oi_a !== 2'd0 || rdy_a !== 4'b0000) begin
        errors++;
        $display("FAIL backpressure got v=%b d=%h i=%0d rdy=%b exp v=1 d=1 i=0 rdy=0000",
                 ov_a, od_a, oi_a, rdy_a);
      end
    end
    out_ready = 1'b1;
    tick("bp_release");
    checks++;
    if (ov_a !== 1'b1 || oi_a !== 2'd1 || od_a !== in_data[W +: W]) begin
      errors++;
      $display("FAIL bp_release got v=%b i=%0d d=%h exp v=1 i=1 d=%h", ov_a, oi_a, od_a, in_data[W +: W]);
    end
  endtask

  task automatic test_wrap_skip();
    logic [3:0] vseq [4];
    int         iseq [4];
    vseq[0] = 4'b0100; iseq[0] = 2;
    vseq[1] = 4'b0010; iseq[1] = 1;
    vseq[2] = 4'b1001; iseq[2] = 3;
    vseq[3] = 4'b1111; iseq[3] = 0;
    rst = 1'b1; tick("wrap_rst");
    rst = 1'b0; mode = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_valid = vseq[k]; fill_data();
      tick("wrap");
      checks++;
      if (ov_a !== 1'b1 || oi_a !== IW'(iseq[k])) begin
        errors++;
        $display("FAIL wrap_skip step %0d got i=%0d exp %0d", k, oi_a, iseq[k]);
      end
    end
  endtask

  task automatic test_reset_mid();
    mode = 1'b0; in_valid = 4'b0100; out_ready = 1'b1; fill_data();
    tick("mid_load");
    out_ready = 1'b0; rst = 1'b1; in_valid = 4'b1111;
    tick("mid_rst");
    checks++;
    if (ov_a !== 1'b0 || od_a !== '0 || oi_a !== '0) begin
      errors++;
      $display("FAIL reset_mid got v=%b d=%h i=%0d exp 0", ov_a, od_a, oi_a);
    end
    rst = 1'b0; out_ready = 1'b1;
    tick("mid_after");
    checks++;
    if (oi_a !== 2'd0 || ov_a !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_ptr got i=%0d v=%b exp i=0 v=1", oi_a, ov_a);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      rst       = ($urandom_range(0, 49) == 0);
      mode      = ($urandom_range(0, 3) == 0);
      sel_index = IW'($urandom_range(0, N-1));
      in_valid  = N'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      fill_data();
      tick("rand");
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_forced();
    test_fairness();
    test_back_to_back();
    test_wrap_skip();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_arb_n.md
Name: mux_arb_n

Overview:
- Parametrised N-channel, WIDTH-bit multiplexer with valid/ready handshakes on every input and on the output.
- Two selection modes:
  - forced-index mode: the caller picks the channel with a select index.
  - arbitrated mode: fixed-priority or round-robin selection among requesting channels.
- The selected word is captured in an output register stage.
- Sits between multiple producers (register-file read ports, ALU results, memory return) and a single consumer in the datapath.

Parameters:
- WIDTH, 32, data width per channel.
- N, 4, number of input channels (N >= 2).
- IDX_W, 2, width of channel index; must equal ceil(log2(N)).
- RR, 1, arbitration policy in arbitrated mode: 1 = round-robin, 0 = fixed priority (channel 0 highest).

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- mode  input  1  0 = arbitrated, 1 = forced index.
- sel_index  input  IDX_W  channel index used when mode=1.
- in_valid  input  N  per-channel request; bit i belongs to channel i.
- in_data  input  N*WIDTH  flattened channel data; channel i occupies bits [i*WIDTH +: WIDTH].
- in_ready  output  N  per-channel accept; at most one bit set in any cycle.
- out_valid  output  1  output register holds a valid word.
- out_data  output  WIDTH  registered selected data.
- out_index  output  IDX_W  channel index the held word came from.
- out_ready  input  1  consumer accepts the output word.

Behaviour:
- Reset (rst=1 at a clk edge):
  - out_valid=0, out_data=0, out_index=0, round-robin pointer ptr=0.
  - Any held word is discarded.
  - in_ready=0 during the cycle rst is high.
- load = !out_valid || out_ready. The output register can accept a new word only when load=1.
- Grant (combinational, evaluated every cycle; no grant when load=0):
  - mode=1: grant channel sel_index if sel_index < N and in_valid[sel_index]=1; otherwise no grant. Other channels are never granted, even if valid.
  - mode=0, RR=0: grant the lowest-numbered i with in_valid[i]=1.
  - mode=0, RR=1: grant the first i with in_valid[i]=1, searching ptr, ptr+1, ... with wrap modulo N.
- in_ready = one-hot grant vector; all zeros when there is no grant. in_ready depends combinationally on out_ready, in_valid, mode and sel_index. It must not depend on in_data.
- Transfer on channel g: in_valid[g] && in_ready[g]. At the next edge: out_valid=1, out_data=in_data[g], out_index=g.
- If load=1 and there is no transfer: out_valid=0 at the next edge. out_data and out_index keep their old values.
- Hold: while out_valid && !out_ready, out_valid, out_data and out_index stay stable.
- Latency: 1 cycle from transfer to out_valid. Throughput: 1 word per cycle when out_ready is held high.
- ptr update:
  - Only on an arbitrated transfer (mode=0): ptr = (g+1) mod N; wrap from N-1 to 0.
  - Forced-mode transfers, and RR=0, leave ptr unchanged.
- Simultaneous events:
  - Output consumed and new input accepted in the same cycle gives a back-to-back word with no bubble.
  - rst has priority over every transfer.
- mode or sel_index may change on any cycle. The change takes effect on the same-cycle grant; a word already held is unaffected.
- sel_index >= N (non-power-of-2 N): no grant, no error, no state change.

Test Plan:
- Reset: rst=1 for 2 cycles while all in_valid=1 -> in_ready=0, out_valid=0, out_data=0, out_index=0. After release, the first grant is channel 0.
- Forced mode: mode=1, sel_index=2, in_valid=4'b1111, in_data ch2=32'hDEADBEEF, out_ready=1 -> in_ready=4'b0100. Next cycle out_valid=1, out_data=32'hDEADBEEF, out_index=2. With sel_index=2 and in_valid[2]=0 -> no grant; out_valid drops.
- Round-robin fairness: RR=1, mode=0, in_valid=4'b1111 constant, out_ready=1 for 8 cycles -> out_index sequence 0,1,2,3,0,1,2,3 with no bubbles. With RR=0 the sequence is all 0.
- Backpressure: out_valid=1 with out_data=32'h1, out_ready=0 for 3 cycles while ch1 requests -> in_ready=0. out_data and out_index stay stable. On out_ready=1, ch1 is accepted in that cycle and appears the next cycle.
- Wrap and skip: N=4, ptr=3, in_valid=4'b0010 -> grant ch1, ptr becomes 2. Then in_valid=4'b1001 -> grant ch3, ptr becomes 0.
- Reset mid-operation: out_valid=1 with out_ready=0, assert rst for one cycle -> out_valid=0, ptr=0, held word lost. No transfer occurs in the reset cycle.
